// File: rtl/boot_pkg.sv
// Shared types and defaults for the UART program loader.
// Holds the loader state enum, bus widths and the byte-lane insert helper.
package boot_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WRITE,
        ST_FINISH
    } boot_state_e;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned COUNT_W = 16;
    localparam int unsigned LANE_W  = 2;

    localparam int unsigned        DEF_WRITE_HOLD   = 16;
    localparam int unsigned        DEF_IDLE_TIMEOUT = 1000;
    localparam logic [ADDR_W-1:0]  DEF_BASE_ADDR    = 32'h0;

    // Return w with byte b placed in lane (little-endian lanes).
    function automatic logic [DATA_W-1:0] lane_insert(input logic [DATA_W-1:0] w,
                                                      input logic [LANE_W-1:0] lane,
                                                      input logic [7:0]        b);
        logic [DATA_W-1:0] r;
        r = w;
        r[8*lane +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/uart_boot_ctrl_if.sv
// CPU write request and arbitrated memory write port of the loader.
interface uart_boot_ctrl_if;
    import boot_pkg::*;

    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    // master: CPU/memory side; slave: the loader arbitrating the port
    modport master (output cpu_we, output cpu_addr, output cpu_wdata,
                    input  mem_we, input  mem_addr, input  mem_wdata);
    modport slave  (input  cpu_we, input  cpu_addr, input  cpu_wdata,
                    output mem_we, output mem_addr, output mem_wdata);
endinterface

// File: rtl/byte_packer.sv
// Packs received bytes into a 32-bit little-endian word, with a one-byte
// skid register that catches a byte arriving while the word is being written.
module byte_packer
    import boot_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              collect_push,
    input  logic              write_rx,
    input  logic              write_exit,
    input  logic [7:0]        rx_data,
    output logic [DATA_W-1:0] word,
    output logic [LANE_W-1:0] lane_idx,
    output logic              drop_c
);

    logic [7:0] skid;
    logic       skid_full;

    // A second byte while the skid is occupied is lost
    assign drop_c = write_rx && skid_full;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            word      <= '0;
            lane_idx  <= '0;
            skid      <= '0;
            skid_full <= 1'b0;
        end else if (write_exit) begin
            // Word register zeroed so unfilled lanes of a later flush read as zero
            skid_full <= 1'b0;
            if (skid_full) begin
                word     <= DATA_W'(skid);
                lane_idx <= LANE_W'(1);
            end else if (write_rx) begin
                word     <= DATA_W'(rx_data);
                lane_idx <= LANE_W'(1);
            end else begin
                word     <= '0;
                lane_idx <= '0;
            end
        end else if (write_rx) begin
            if (!skid_full) begin
                skid      <= rx_data;
                skid_full <= 1'b1;
            end
        end else if (collect_push) begin
            word     <= lane_insert(word, lane_idx, rx_data);
            lane_idx <= lane_idx + LANE_W'(1);
        end
    end

endmodule

// File: rtl/uart_boot_ctrl.sv
// UART boot loader: collects bytes into words, writes them to memory while
// stalling the CPU, and pulses cpu_restart when the load completes.
module uart_boot_ctrl
    import boot_pkg::*;
#(
    parameter int unsigned       WRITE_HOLD   = DEF_WRITE_HOLD,
    parameter int unsigned       IDLE_TIMEOUT = DEF_IDLE_TIMEOUT,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = DEF_BASE_ADDR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    uart_boot_ctrl_if.slave    bus,
    output logic               cpu_stall,
    output logic               cpu_restart,
    output logic               load_busy,
    output logic [COUNT_W-1:0] word_count,
    output logic               overrun
);

    localparam int unsigned HOLD_W = $clog2(WRITE_HOLD + 1);
    localparam int unsigned TO_W   = $clog2(IDLE_TIMEOUT + 1);

    boot_state_e       state;
    logic [ADDR_W-1:0] addr_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic [TO_W-1:0]   idle_cnt;
    logic              flush;

    logic              clear;
    logic              collect_push;
    logic              write_rx;
    logic              write_exit;
    logic              drop_c;
    logic [DATA_W-1:0] word;
    logic [LANE_W-1:0] lane_idx;

    assign clear        = (state == ST_IDLE) && start;
    assign collect_push = (state == ST_COLLECT) && rx_valid;
    assign write_rx     = (state == ST_WRITE) && rx_valid;
    assign write_exit   = (state == ST_WRITE) && (hold_cnt == HOLD_W'(WRITE_HOLD - 1));

    byte_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .collect_push (collect_push),
        .write_rx     (write_rx),
        .write_exit   (write_exit),
        .rx_data      (rx_data),
        .word         (word),
        .lane_idx     (lane_idx),
        .drop_c       (drop_c)
    );

    // Loader sequencing, write hold timing, address and word counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            addr_q     <= BASE_ADDR;
            word_count <= '0;
            overrun    <= 1'b0;
            hold_cnt   <= '0;
            idle_cnt   <= '0;
            flush      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_COLLECT;
                        addr_q     <= BASE_ADDR;
                        word_count <= '0;
                        overrun    <= 1'b0;
                        idle_cnt   <= '0;
                    end
                end
                ST_COLLECT: begin
                    // A byte on the threshold cycle wins over the timeout
                    if (rx_valid) begin
                        idle_cnt <= '0;
                        if (lane_idx == LANE_W'(3)) begin
                            state    <= ST_WRITE;
                            hold_cnt <= '0;
                            flush    <= 1'b0;
                        end
                    end else if (idle_cnt == TO_W'(IDLE_TIMEOUT - 1)) begin
                        idle_cnt <= '0;
                        if (lane_idx == '0) begin
                            state <= ST_FINISH;
                        end else begin
                            state    <= ST_WRITE;
                            hold_cnt <= '0;
                            flush    <= 1'b1;
                        end
                    end else begin
                        idle_cnt <= idle_cnt + TO_W'(1);
                    end
                end
                ST_WRITE: begin
                    if (drop_c) begin
                        overrun <= 1'b1;
                    end
                    if (write_exit) begin
                        addr_q     <= addr_q + ADDR_W'(4);
                        word_count <= (word_count == '1) ? word_count
                                                         : word_count + COUNT_W'(1);
                        idle_cnt   <= '0;
                        state      <= flush ? ST_FINISH : ST_COLLECT;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign load_busy   = (state != ST_IDLE);
    assign cpu_stall   = (state != ST_IDLE);
    assign cpu_restart = (state == ST_FINISH);

    // Memory port: CPU passes through in IDLE, loader owns it otherwise
    always_comb begin
        bus.mem_we    = bus.cpu_we;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        if (state != ST_IDLE) begin
            bus.mem_we    = (state == ST_WRITE);
            bus.mem_addr  = addr_q;
            bus.mem_wdata = word;
        end
    end

endmodule

// File: tb/tb_uart_boot_ctrl.sv
// Self-checking bench for uart_boot_ctrl: a word-level write scoreboard built
// from the byte stream, checked every cycle, plus literal spot checks.
module tb_uart_boot_ctrl;
    import boot_pkg::*;

    localparam int unsigned        H    = 4;
    localparam int unsigned        T    = 12;
    localparam logic [ADDR_W-1:0]  BASE = 32'h0;

    logic        clk = 1'b0;
    logic        reset, start, rx_valid;
    logic [7:0]  rx_data;
    logic        cpu_stall, cpu_restart, load_busy, overrun;
    logic [15:0] word_count;

    uart_boot_ctrl_if bus ();

    uart_boot_ctrl #(.WRITE_HOLD(H), .IDLE_TIMEOUT(T), .BASE_ADDR(BASE)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .bus         (bus),
        .cpu_stall   (cpu_stall),
        .cpu_restart (cpu_restart),
        .load_busy   (load_busy),
        .word_count  (word_count),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [7:0]  mb[$];
    int          run_len = 0;
    int          cyc = 0;
    int          last_we_cyc = 0;
    int          restart_cyc = 0;
    int          restart_cnt = 0;
    logic        prev_restart = 1'b0;
    logic [31:0] last_waddr = '0;
    logic [31:0] last_wdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected writes: bytes packed little-endian, trailing partial word zero-filled
    task automatic model_push();
        int nw;
        logic [31:0] d;
        nw = (mb.size() + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            d = '0;
            for (int k = 0; k < 4; k++) begin
                if (w * 4 + k < mb.size()) d[8*k +: 8] = mb[w*4 + k];
            end
            exp_addr.push_back(BASE + 32'(4 * w));
            exp_data.push_back(d);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            run_len = 0;
            exp_addr.delete();
            exp_data.delete();
            prev_restart = 1'b0;
        end else begin
            check("stall_eq_busy", 32'(cpu_stall), 32'(load_busy));
            if (!load_busy) begin
                check("pass_we",    32'(bus.mem_we), 32'(bus.cpu_we));
                check("pass_addr",  bus.mem_addr,    bus.cpu_addr);
                check("pass_wdata", bus.mem_wdata,   bus.cpu_wdata);
                check("restart_idle", 32'(cpu_restart), 32'(0));
            end else begin
                if (bus.mem_we) begin
                    check("write_expected", 32'(exp_addr.size() > 0), 32'(1));
                    if (exp_addr.size() > 0) begin
                        check("write_addr",  bus.mem_addr,  exp_addr[0]);
                        check("write_wdata", bus.mem_wdata, exp_data[0]);
                    end
                    run_len++;
                    last_we_cyc = cyc;
                    last_waddr  = bus.mem_addr;
                    last_wdata  = bus.mem_wdata;
                end else if (run_len != 0) begin
                    check("write_hold_len", 32'(run_len), 32'(H));
                    if (exp_addr.size() > 0) begin
                        void'(exp_addr.pop_front());
                        void'(exp_data.pop_front());
                    end
                    run_len = 0;
                end
                if (cpu_restart) begin
                    restart_cnt++;
                    restart_cyc = cyc;
                    check("restart_width", 32'(prev_restart), 32'(0));
                    check("writes_done_at_finish", 32'(exp_addr.size()), 32'(0));
                end
            end
            prev_restart = cpu_restart;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send4(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
        send(b0); idle(1);
        send(b1); idle(1);
        send(b2); idle(1);
        send(b3);
    endtask

    task automatic begin_load();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_restart(input string name, input int max);
        int c;
        c = restart_cnt;
        for (int k = 0; k < max && restart_cnt == c; k++) tick();
        check(name, 32'(restart_cnt - c), 32'(1));
        tick();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = '0;
        bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        idle(2);
        check("rst_stall",   32'(cpu_stall),   32'(0));
        check("rst_restart", 32'(cpu_restart), 32'(0));
        check("rst_busy",    32'(load_busy),   32'(0));
        check("rst_wcount",  32'(word_count),  32'(0));
        check("rst_overrun", 32'(overrun),     32'(0));
        reset = 1'b0;
        idle(1);

        // CPU pass-through while idle
        bus.cpu_we = 1'b1; bus.cpu_addr = 32'h100; bus.cpu_wdata = 32'hDEADBEEF;
        idle(1);
        check("idle_we",    32'(bus.mem_we), 32'(1));
        check("idle_addr",  bus.mem_addr,    32'h100);
        check("idle_wdata", bus.mem_wdata,   32'hDEADBEEF);

        // Single word, CPU request held active and discarded
        mb = '{8'h11, 8'h22, 8'h33, 8'h44};
        model_push();
        begin_load();
        check("load_busy",  32'(load_busy),  32'(1));
        check("load_stall", 32'(cpu_stall),  32'(1));
        check("load_cpu_we_blocked", 32'(bus.mem_we), 32'(0));
        send4(8'h11, 8'h22, 8'h33, 8'h44);
        idle(H + 1);
        check("w1_data",   last_wdata,       32'h44332211);
        check("w1_addr",   last_waddr,       32'h0);
        check("w1_wcount", 32'(word_count),  32'(1));
        bus.cpu_we = 1'b0;
        wait_restart("w1_restart", T + 10);

        // Two words then silence: FINISH after T idle cycles
        mb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        model_push();
        begin_load();
        send4(8'h01, 8'h02, 8'h03, 8'h04);
        idle(H);
        send4(8'h05, 8'h06, 8'h07, 8'h08);
        wait_restart("w2_restart", H + T + 10);
        check("w2_finish_gap", 32'(restart_cyc - last_we_cyc), 32'(T + 1));
        check("w2_last_data",  last_wdata,      32'h08070605);
        check("w2_last_addr",  last_waddr,      32'h4);
        check("w2_wcount",     32'(word_count), 32'(2));

        // Partial word flushed by timeout
        mb = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        model_push();
        begin_load();
        send4(8'hAA, 8'hBB, 8'hCC, 8'hDD);
        idle(H);
        send(8'hEE);
        wait_restart("w3_restart", 2 * H + T + 10);
        check("w3_finish_gap", 32'(restart_cyc - last_we_cyc), 32'(1));
        check("w3_flush_data", last_wdata,      32'h000000EE);
        check("w3_flush_addr", last_waddr,      32'h4);
        check("w3_wcount",     32'(word_count), 32'(2));

        // Skid byte, then a dropped byte with overrun
        mb = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3,
               8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hD0, 8'hD2, 8'hD3, 8'hD4};
        model_push();
        begin_load();
        send4(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        idle(1);
        send(8'hB0);
        idle(H - 2);
        send(8'hB1); idle(1); send(8'hB2); idle(1); send(8'hB3);
        idle(H);
        send4(8'hC0, 8'hC1, 8'hC2, 8'hC3);
        send(8'hD0);
        send(8'hD1);
        idle(H - 2);
        send(8'hD2); idle(1); send(8'hD3); idle(1); send(8'hD4);
        wait_restart("w4_restart", H + T + 10);
        check("w4_overrun",   32'(overrun),     32'(1));
        check("w4_last_data", last_wdata,       32'hD4D3D2D0);
        check("w4_wcount",    32'(word_count),  32'(4));

        // Start clears overrun; empty load times out without writes
        mb.delete();
        begin_load();
        check("w5_overrun_cleared", 32'(overrun), 32'(0));
        wait_restart("w5_restart", T + 10);
        check("w5_wcount", 32'(word_count), 32'(0));

        // Reset in the third WRITE cycle
        mb = '{8'h9A, 8'h9B, 8'h9C, 8'h9D};
        model_push();
        begin_load();
        send4(8'h9A, 8'h9B, 8'h9C, 8'h9D);
        idle(2);
        check("w6_in_write", 32'(bus.mem_we), 32'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("w6_we_off",  32'(bus.mem_we),    32'(0));
        check("w6_busy",    32'(load_busy),     32'(0));
        check("w6_wcount",  32'(word_count),    32'(0));
        idle(3);
        check("w6_no_retry", 32'(bus.mem_we),   32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
